// File: rtl/sonata_reg_bus_arbiter_pkg.sv
// Shared types and constants for the register bus arbiter.
package sonata_reg_bus_arbiter_pkg;

    // ISSUE is a same-cycle view only; the state register never holds it.
    typedef enum logic [1:0] {
        StIdle,
        StHoldoff,
        StIssue,
        StRdwait
    } arb_state_e;

    localparam int unsigned DefaultAddrWidth   = 21;
    localparam int unsigned DefaultBytecntSize = 7;
    localparam int unsigned DefaultHoldoff     = 8;

    // Register address field width: the byte-count bits are stripped off the host address.
    function automatic int unsigned reg_addr_width(int unsigned addr_width,
                                                   int unsigned bytecnt_size);
        return addr_width - bytecnt_size;
    endfunction

    // Holdoff counter must be able to hold the value holdoff itself.
    function automatic int unsigned holdoff_cnt_width(int unsigned holdoff);
        return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/sonata_reg_bus_arbiter_if.sv
// Byte-wide valid/ready handshake between the register sequencer and the arbiter.
interface sonata_reg_bus_arbiter_if
    import sonata_reg_bus_arbiter_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH   = DefaultAddrWidth,
    parameter int unsigned pBYTECNT_SIZE = DefaultBytecntSize
) ();
    logic                                 m_valid;
    logic                                 m_we;
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] m_address;
    logic [pBYTECNT_SIZE-1:0]             m_bytecnt;
    logic [7:0]                           m_wdata;
    logic                                 m_ready;
    logic [7:0]                           m_rdata;
    logic                                 m_rvalid;

    // Sequencer side.
    modport master (
        output m_valid, m_we, m_address, m_bytecnt, m_wdata,
        input  m_ready, m_rdata, m_rvalid
    );

    // Arbiter side.
    modport slave (
        input  m_valid, m_we, m_address, m_bytecnt, m_wdata,
        output m_ready, m_rdata, m_rvalid
    );
endinterface

// File: rtl/sonata_sat_counter.sv
// Generic up-counter that sticks at all-ones instead of wrapping.
module sonata_sat_counter #(
    parameter int unsigned pWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [pWIDTH-1:0] count
);
    logic [pWIDTH-1:0] count_q;

    // Count up on inc, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + pWIDTH'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/sonata_reg_bus_arbiter.sv
// Register bus arbiter: USB host has absolute zero-latency priority, the sequencer
// is granted only after the host has been idle for pHOLDOFF cycles.
// Optional stall statistic enabled by defining SONATA_REG_ARB_STATS_EN.
module sonata_reg_bus_arbiter
    import sonata_reg_bus_arbiter_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH   = DefaultAddrWidth,
    parameter int unsigned pBYTECNT_SIZE = DefaultBytecntSize,
    parameter int unsigned pHOLDOFF      = DefaultHoldoff,
    parameter int unsigned pSTAT_WIDTH   = 16
) (
    input  logic                                 usb_clk,
    input  logic                                 rst_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] h_address,
    input  logic [pBYTECNT_SIZE-1:0]             h_bytecnt,
    input  logic [7:0]                           h_datao,
    input  logic                                 h_read,
    input  logic                                 h_write,
    output logic [7:0]                           h_datai,
    sonata_reg_bus_arbiter_if.slave              seq,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    output logic                                 reg_read,
    output logic                                 reg_write,
    input  logic [7:0]                           reg_datai,
    output logic                                 host_busy,
    output logic [pSTAT_WIDTH-1:0]               stall_count
);
    localparam int unsigned RegAw = reg_addr_width(pADDR_WIDTH, pBYTECNT_SIZE);
    localparam int unsigned CntW  = holdoff_cnt_width(pHOLDOFF);
    localparam logic [CntW-1:0] HoldoffVal = CntW'(pHOLDOFF);

    logic                     h_active;
    logic                     issue;
    logic [CntW-1:0]          cnt_q, cnt_d;
    arb_state_e               state_q, state_d, cur_state;
    logic [RegAw-1:0]         addr_q;
    logic [pBYTECNT_SIZE-1:0] bytecnt_q;
    logic [7:0]               datao_q;
    logic [7:0]               rdata_q;

    assign h_active  = h_read | h_write;
    assign host_busy = h_active | (cnt_q != '0);
    assign h_datai   = reg_datai;

    // Holdoff counter: reload on any host cycle, otherwise run down to zero.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= HoldoffVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // FSM state register; reset lands in HOLDOFF so the sequencer is blocked.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHoldoff;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant needs a quiet host and an expired holdoff.
    always_comb begin
        cnt_d     = h_active ? HoldoffVal : ((cnt_q != '0) ? cnt_q - CntW'(1) : '0);
        issue     = seq.m_valid & ~h_active & (cnt_q == '0);
        cur_state = issue ? StIssue : state_q;
        if (issue && !seq.m_we) begin
            state_d = StRdwait;
        end else if (cnt_d != '0) begin
            state_d = StHoldoff;
        end else begin
            state_d = StIdle;
        end
    end

    // Output mux: host combinationally, sequencer on ISSUE, else hold the shadows.
    always_comb begin
        reg_address  = addr_q;
        reg_bytecnt  = bytecnt_q;
        reg_datao    = datao_q;
        reg_read     = 1'b0;
        reg_write    = 1'b0;
        seq.m_ready  = 1'b0;
        seq.m_rvalid = (state_q == StRdwait);
        // Read data is live in RDWAIT and held from the capture register afterwards.
        seq.m_rdata  = (state_q == StRdwait) ? reg_datai : rdata_q;
        if (h_active) begin
            reg_address = h_address;
            reg_bytecnt = h_bytecnt;
            reg_datao   = h_datao;
            reg_read    = h_read;
            reg_write   = h_write;
        end else if (cur_state == StIssue) begin
            reg_address = seq.m_address;
            reg_bytecnt = seq.m_bytecnt;
            reg_datao   = seq.m_wdata;
            reg_read    = ~seq.m_we;
            reg_write   = seq.m_we;
            seq.m_ready = 1'b1;
        end
    end

    // Shadow of the last driven bus values, and the sequencer read-data capture.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            bytecnt_q <= '0;
            datao_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (h_active || issue) begin
                addr_q    <= reg_address;
                bytecnt_q <= reg_bytecnt;
                datao_q   <= reg_datao;
            end
            if (state_q == StRdwait) begin
                rdata_q <= reg_datai;
            end
        end
    end

`ifdef SONATA_REG_ARB_STATS_EN
    sonata_sat_counter #(
        .pWIDTH (pSTAT_WIDTH)
    ) u_stall_cnt (
        .clk   (usb_clk),
        .rst_n (rst_n),
        .inc   (seq.m_valid & ~issue),
        .count (stall_count)
    );
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_sonata_reg_bus_arbiter.sv
// Self-checking bench for sonata_reg_bus_arbiter: per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_sonata_reg_bus_arbiter;
    localparam int unsigned AW  = 21;
    localparam int unsigned BC  = 7;
    localparam int unsigned RAW = AW - BC;
    localparam int unsigned H   = 8;
    localparam int unsigned SW  = 16;

    logic usb_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 usb_clk = ~usb_clk;

    logic [RAW-1:0] h_address;
    logic [BC-1:0]  h_bytecnt;
    logic [7:0]     h_datao;
    logic           h_read, h_write;
    logic [7:0]     h_datai;
    logic [RAW-1:0] reg_address;
    logic [BC-1:0]  reg_bytecnt;
    logic [7:0]     reg_datao;
    logic           reg_read, reg_write;
    logic [7:0]     reg_datai;
    logic           host_busy;
    logic [SW-1:0]  stall_count;

    // Second instance with a 4-bit statistic; only its stall_count is examined.
    logic [7:0]     h_datai4, reg_datao4;
    logic [RAW-1:0] reg_address4;
    logic [BC-1:0]  reg_bytecnt4;
    logic           reg_read4, reg_write4, host_busy4;
    logic [3:0]     stall_count4;

    sonata_reg_bus_arbiter_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) sif ();
    sonata_reg_bus_arbiter_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) sif4 ();

    sonata_reg_bus_arbiter #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pHOLDOFF(H), .pSTAT_WIDTH(SW)
    ) dut (
        .usb_clk(usb_clk), .rst_n(rst_n), .h_address(h_address), .h_bytecnt(h_bytecnt),
        .h_datao(h_datao), .h_read(h_read), .h_write(h_write), .h_datai(h_datai),
        .seq(sif.slave), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
        .reg_datai(reg_datai), .host_busy(host_busy), .stall_count(stall_count)
    );

    sonata_reg_bus_arbiter #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pHOLDOFF(H), .pSTAT_WIDTH(4)
    ) dut4 (
        .usb_clk(usb_clk), .rst_n(rst_n), .h_address(h_address), .h_bytecnt(h_bytecnt),
        .h_datao(h_datao), .h_read(h_read), .h_write(h_write), .h_datai(h_datai4),
        .seq(sif4.slave), .reg_address(reg_address4), .reg_bytecnt(reg_bytecnt4),
        .reg_datao(reg_datao4), .reg_read(reg_read4), .reg_write(reg_write4),
        .reg_datai(reg_datai), .host_busy(host_busy4), .stall_count(stall_count4)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: idle_edges counts rising edges since the host (or reset)
    // last held the bus; the sequencer may go once H quiet edges have passed.
    int             idle_edges;
    bit             rd_pending;
    logic [7:0]     cap_data;
    logic [RAW-1:0] sh_addr;
    logic [BC-1:0]  sh_bc;
    logic [7:0]     sh_data;
    int             stall_m;

    initial begin : model
        logic           ha, grant, er, ew;
        logic [RAW-1:0] ea;
        logic [BC-1:0]  eb;
        logic [7:0]     ed;
        int             exp_stall;
        forever begin
            @(negedge usb_clk);
            if (!rst_n) begin
                chk("rst m_ready", sif.m_ready, 0);
                chk("rst m_rvalid", sif.m_rvalid, 0);
                chk("rst m_rdata", sif.m_rdata, 0);
                chk("rst reg_read", reg_read, 0);
                chk("rst reg_write", reg_write, 0);
                chk("rst reg_address", reg_address, 0);
                chk("rst host_busy", host_busy, 1);
                chk("rst stall_count", stall_count, 0);
                idle_edges = 0; rd_pending = 0; cap_data = 0;
                sh_addr = 0; sh_bc = 0; sh_data = 0; stall_m = 0;
            end else begin
                ha    = h_read | h_write;
                grant = sif.m_valid && !ha && (idle_edges >= H);
                if (ha) begin
                    ea = h_address; eb = h_bytecnt; ed = h_datao; er = h_read; ew = h_write;
                end else if (grant) begin
                    ea = sif.m_address; eb = sif.m_bytecnt; ed = sif.m_wdata;
                    er = !sif.m_we; ew = sif.m_we;
                end else begin
                    ea = sh_addr; eb = sh_bc; ed = sh_data; er = 0; ew = 0;
                end
`ifdef SONATA_REG_ARB_STATS_EN
                exp_stall = stall_m;
`else
                exp_stall = 0;
`endif
                chk("m_ready", sif.m_ready, grant);
                chk("host_busy", host_busy, ha || (idle_edges < H));
                chk("m_rvalid", sif.m_rvalid, rd_pending);
                chk("m_rdata", sif.m_rdata, rd_pending ? reg_datai : cap_data);
                chk("h_datai", h_datai, reg_datai);
                chk("reg_address", reg_address, ea);
                chk("reg_bytecnt", reg_bytecnt, eb);
                chk("reg_datao", reg_datao, ed);
                chk("reg_read", reg_read, er);
                chk("reg_write", reg_write, ew);
                chk("stall_count", stall_count, exp_stall);
                // Advance to the state after the coming rising edge.
                if (rd_pending) cap_data = reg_datai;
                rd_pending = grant && !sif.m_we;
                if (ha || grant) begin
                    sh_addr = ea; sh_bc = eb; sh_data = ed;
                end
                if (ha) idle_edges = 0;
                else if (idle_edges < H) idle_edges++;
                if (sif.m_valid && !grant && stall_m < (2 ** SW - 1)) stall_m++;
            end
        end
    end

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    // n = index of the rising edge (from now) that takes the handshake; -1 on timeout.
    task automatic wait_ready(output int n);
        n = 0;
        repeat (40) begin
            @(negedge usb_clk);
            n++;
            if (sif.m_ready) return;
        end
        n = -1;
    endtask

    int n;
    int pulses;

    initial begin
        h_address = 0; h_bytecnt = 0; h_datao = 0; h_read = 0; h_write = 0;
        reg_datai = 0;
        sif.m_valid = 1; sif.m_we = 1; sif.m_address = 14'h0A; sif.m_bytecnt = 0;
        sif.m_wdata = 8'h5C;
        sif4.m_valid = 1; sif4.m_we = 1; sif4.m_address = 0; sif4.m_bytecnt = 0;
        sif4.m_wdata = 0;

        // Reset release with a write request waiting: handshake on edge H+1.
        repeat (3) step();
        rst_n = 1;
        wait_ready(n);
        chk("first grant edge after reset", n, H + 1);
        chk("first grant reg_write", reg_write, 1);

        // Host write wins while the sequencer keeps requesting.
        step();
        h_address = 14'h12; h_bytecnt = 3; h_datao = 8'hA5; h_write = 1;
        sif.m_address = 14'h55; sif.m_wdata = 8'h99;
        @(negedge usb_clk);
        chk("host wr reg_write", reg_write, 1);
        chk("host wr reg_address", reg_address, 14'h12);
        chk("host wr reg_bytecnt", reg_bytecnt, 3);
        chk("host wr reg_datao", reg_datao, 8'hA5);
        chk("host wr m_ready", sif.m_ready, 0);
        step();
        h_write = 0;
        wait_ready(n);
        chk("grant edge after host", n, H + 1);
        chk("grant reg_address", reg_address, 14'h55);

        // Sequencer read of 0x04 returning 0x3C.
        step();
        sif.m_we = 0; sif.m_address = 14'h04;
        @(negedge usb_clk);
        chk("seq rd m_ready", sif.m_ready, 1);
        chk("seq rd reg_read", reg_read, 1);
        chk("seq rd reg_address", reg_address, 14'h04);
        step();
        sif.m_valid = 0; reg_datai = 8'h3C;
        @(negedge usb_clk);
        chk("seq rd m_rvalid", sif.m_rvalid, 1);
        chk("seq rd m_rdata", sif.m_rdata, 8'h3C);
        step();
        reg_datai = 8'h00;
        @(negedge usb_clk);
        chk("seq rd m_rvalid once", sif.m_rvalid, 0);
        chk("seq rd m_rdata held", sif.m_rdata, 8'h3C);

        // Host read starts in the sequencer's RDWAIT cycle.
        step();
        sif.m_valid = 1; sif.m_address = 14'h07; reg_datai = 8'h11;
        @(negedge usb_clk);
        chk("rd2 m_ready", sif.m_ready, 1);
        step();
        sif.m_valid = 0; h_read = 1; h_address = 14'h20; reg_datai = 8'h5A;
        @(negedge usb_clk);
        chk("rd2 m_rvalid", sif.m_rvalid, 1);
        chk("rd2 m_rdata", sif.m_rdata, 8'h5A);
        chk("rd2 h_datai", h_datai, 8'h5A);
        chk("rd2 reg_read host", reg_read, 1);
        chk("rd2 reg_address host", reg_address, 14'h20);
        step();
        reg_datai = 8'h6B;
        @(negedge usb_clk);
        chk("rd2 h_datai tracks", h_datai, 8'h6B);
        chk("rd2 m_rdata held", sif.m_rdata, 8'h5A);
        step();
        h_read = 0; reg_datai = 0;

        // Stall statistic: 20 host cycles plus holdoff with the request held.
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        repeat (H + 3) step();
        h_write = 1; h_address = 14'h30; sif.m_valid = 1; sif.m_we = 1;
        repeat (20) step();
        h_write = 0;
        wait_ready(n);
        chk("burst grant edge", n, H + 1);
        step();
        sif.m_valid = 0;
        @(negedge usb_clk);
`ifdef SONATA_REG_ARB_STATS_EN
        chk("stall_count burst", stall_count, 20 + H);
        chk("stall_count 4-bit saturated", stall_count4, 15);
`else
        chk("stall_count tied off", stall_count, 0);
        chk("stall_count4 tied off", stall_count4, 0);
`endif

        // Reset during RDWAIT: capture dropped, no m_rvalid.
        step();
        sif.m_valid = 1; sif.m_we = 0; sif.m_address = 14'h09;
        @(negedge usb_clk);
        chk("rdwait rst m_ready", sif.m_ready, 1);
        step();
        sif.m_valid = 0; rst_n = 0; reg_datai = 8'h77;
        @(negedge usb_clk);
        chk("rdwait rst m_rvalid", sif.m_rvalid, 0);
        chk("rdwait rst m_rdata", sif.m_rdata, 0);
        chk("rdwait rst reg_datao", reg_datao, 0);
        step();
        step();
        rst_n = 1;
        pulses = 0;
        repeat (12) begin
            @(negedge usb_clk);
            if (sif.m_rvalid) pulses++;
        end
        chk("rdwait rst no rvalid after", pulses, 0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sonata_reg_bus_arbiter.md
# sonata_reg_bus_arbiter

Shares the single internal register bus between two masters. The USB host front end cannot be stalled; the on-chip register sequencer uses a byte-wide valid/ready handshake. The arbiter sits between the USB register front end and the register decode/read-mux logic. The host always has absolute, zero-latency priority, and the sequencer is granted only after the host has been quiet for a programmable holdoff.

## Interface
Parameters:
- pADDR_WIDTH, 21, full host address width.
- pBYTECNT_SIZE, 7, byte-count field width; the register address is bits [pADDR_WIDTH-1:pBYTECNT_SIZE].
- pHOLDOFF, 8, idle host cycles required before the sequencer may issue; must be at least 1.
- pSTAT_WIDTH, 16, width of the stall statistic counter.

Ports:
- usb_clk, in, 1: sole clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- h_address, in, pADDR_WIDTH-pBYTECNT_SIZE: host register address.
- h_bytecnt, in, pBYTECNT_SIZE: host byte index.
- h_datao, in, 8: host write data.
- h_read, in, 1: host read level.
- h_write, in, 1: host write strobe.
- h_datai, out, 8: read data returned to the host.
- m_valid, in, 1: sequencer byte request.
- m_we, in, 1: request is a write (1) or a read (0).
- m_address, in, pADDR_WIDTH-pBYTECNT_SIZE: sequencer register address.
- m_bytecnt, in, pBYTECNT_SIZE: sequencer byte index.
- m_wdata, in, 8: sequencer write data.
- m_ready, out, 1: request accepted this cycle.
- m_rdata, out, 8: captured read data.
- m_rvalid, out, 1: one-cycle pulse marking m_rdata valid.
- reg_address, out, pADDR_WIDTH-pBYTECNT_SIZE: to register decode.
- reg_bytecnt, out, pBYTECNT_SIZE: to register decode.
- reg_datao, out, 8: to register decode.
- reg_read, out, 1: to register decode.
- reg_write, out, 1: to register decode.
- reg_datai, in, 8: register read data, valid one cycle after reg_read.
- host_busy, out, 1: host active or holdoff running.
- stall_count, out, pSTAT_WIDTH: sequencer stall statistic.

## Operation
- h_active = h_read | h_write.
- Host path is combinational. When h_active is high, reg_* follow h_* in the same cycle, and h_datai = reg_datai always.
- Holdoff counter:
  - reloads to pHOLDOFF on every h_active cycle;
  - otherwise decrements to 0;
  - host_busy = h_active | (counter != 0).
- FSM states:
  - IDLE: counter == 0 and no request pending.
  - HOLDOFF: counter != 0; m_ready is held at 0.
  - ISSUE: combinational only. Entered when m_valid & ~h_active & counter == 0.
    - m_ready = 1 that cycle.
    - reg_* are driven from m_*.
    - reg_write = m_we.
    - reg_read = ~m_we.
  - RDWAIT: one cycle after a read ISSUE.
    - m_rdata <= reg_datai and m_rvalid pulses; both are taken from reg_datai that cycle.
    - This capture happens even if h_active rises in that cycle; the host takes the bus combinationally.
    - A new ISSUE is allowed from RDWAIT in the same cycle.
- No same-cycle collision can occur, because ISSUE requires ~h_active.
- The sequencer accepts at most one byte per cycle, so back-to-back writes run at 1 byte/cycle.
- When neither side is active:
  - reg_read = 0 and reg_write = 0;
  - reg_address, reg_bytecnt and reg_datao hold their last driven values (registered shadow).
- Reset (asynchronous):
  - holdoff counter = pHOLDOFF, so the sequencer is blocked after reset;
  - FSM goes to HOLDOFF;
  - m_ready = 0, m_rvalid = 0, m_rdata = 0;
  - reg_read = 0, reg_write = 0, address shadows = 0;
  - stall_count = 0.
- Reset asserted while in RDWAIT discards the pending capture, and no m_rvalid is emitted.

## Timing
- Host to reg_*: 0 cycles.
- Sequencer write: accepted and strobed in cycle t.
- Sequencer read: strobe in cycle t; m_rdata and m_rvalid appear in t+1.
- First sequencer grant after the last host cycle: exactly pHOLDOFF+1 cycles later.
- stall_count:
  - increments on each cycle with m_valid & ~m_ready;
  - saturates at all-ones and does not wrap.

## Configuration
- SONATA_REG_ARB_STATS_EN defined: stall_count is implemented as described.
- Undefined: stall_count is tied to 0 and no counter logic is generated.

## Structure
- A shared package holds:
  - FSM state enum (IDLE, HOLDOFF, ISSUE, RDWAIT);
  - default holdoff constant;
  - the address/bytecnt width derivations.
- One natural sub-module: sonata_sat_counter, a generic saturating counter used for stall_count.

## Test plan
- Host write to address 0x12, bytecnt 3, data 0xA5 with m_valid held high: reg_write with 0xA5 in the same cycle; m_ready stays 0.
- Host idle; after reset release with m_valid=1, m_we=1: first m_ready occurs exactly pHOLDOFF+1 cycles after rst_n rises.
- Sequencer read of address 0x04 where reg_datai=0x3C: m_rvalid pulses once with m_rdata=0x3C one cycle after m_ready.
- Host read begins the cycle after a sequencer read issue: m_rdata still captures the sequencer data, and h_datai tracks the host read.
- rst_n asserted during RDWAIT: m_rvalid is never asserted and all outputs are at reset values.
- With the macro defined: holding m_valid through a 20-cycle host burst plus pHOLDOFF gives stall_count = 20 + pHOLDOFF.
- With pSTAT_WIDTH=4 and the macro defined, a long stall saturates stall_count at 15.
